// File: rtl/game_state_controller.sv
// Game state controller: IDLE/PLAYING/GAMEOVER sequencing, bird physics,
// collision detection against three pipes and saturating score keeping.
module game_state_controller #(
    parameter int TICK_DIVIDER    = 50000,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int BIRD_X          = 120,
    parameter int BIRD_SIZE       = 24,
    parameter int PIPE_WIDTH      = 52,
    parameter int PIPE_GAP_HEIGHT = 100,
    parameter int START_Y         = 240,
    parameter int FLAP_VELOCITY   = -8,
    parameter int GRAVITY         = 1,
    parameter int MAX_FALL        = 8,
    parameter int HOLD_CYCLES     = 1000000
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iFlap,
    input  logic signed [31:0] iPipe1X,
    input  logic signed [31:0] iPipe2X,
    input  logic signed [31:0] iPipe3X,
    input  logic signed [31:0] iPipe1Y,
    input  logic signed [31:0] iPipe2Y,
    input  logic signed [31:0] iPipe3Y,
    output logic [1:0]         oState,
    output logic signed [31:0] oBirdY,
    output logic [15:0]        oScore
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PLAYING  = 2'd1,
        S_GAMEOVER = 2'd2,
        S_ILLEGAL  = 2'd3
    } state_t;

    localparam logic signed [31:0] SCREEN_H_S  = 32'(SCREEN_HEIGHT);
    localparam logic signed [31:0] BIRD_X_S    = 32'(BIRD_X);
    localparam logic signed [31:0] BIRD_SIZE_S = 32'(BIRD_SIZE);
    localparam logic signed [31:0] BIRD_R_S    = 32'(BIRD_X + BIRD_SIZE);
    localparam logic signed [31:0] PIPE_W_S    = 32'(PIPE_WIDTH);
    localparam logic signed [31:0] GAP_S       = 32'(PIPE_GAP_HEIGHT);
    localparam logic signed [31:0] START_Y_S   = 32'(START_Y);
    localparam logic signed [31:0] NO_PIPE     = -32'sd1;
    localparam logic signed [7:0]  FLAP_V_S    = 8'(FLAP_VELOCITY);
    localparam logic signed [8:0]  GRAVITY_S   = 9'(GRAVITY);
    localparam logic signed [8:0]  MAX_FALL_S9 = 9'(MAX_FALL);
    localparam logic signed [7:0]  MAX_FALL_S8 = 8'(MAX_FALL);
    localparam logic [31:0]        TICK_LAST   = 32'(TICK_DIVIDER - 1);
    localparam logic [31:0]        HOLD_LAST   = 32'(HOLD_CYCLES);

    function automatic logic signed [7:0] apply_gravity(input logic signed [7:0] v);
        logic signed [8:0] s;
        s = 9'(v) + GRAVITY_S;
        return (s > MAX_FALL_S9) ? MAX_FALL_S8 : s[7:0];
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] n);
        logic [16:0] s;
        s = {1'b0, a} + 17'(n);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t             state_q, state_d;
    logic signed [31:0] bird_y_q, bird_y_d;
    logic signed [7:0]  vel_q, vel_d;
    logic [15:0]        score_q, score_d;
    logic [31:0]        tick_q, tick_d;
    logic [31:0]        hold_q, hold_d;
    logic [2:0]         passed_q, passed_d;
    logic               flap_q, arm_q;

    logic signed [31:0] pipe_x [3];
    logic signed [31:0] pipe_y [3];
    logic signed [31:0] vel_ext;
    logic               flap_pulse, collide;
    logic [2:0]         passed_nxt;
    logic [1:0]         pass_cnt;

    assign pipe_x[0] = iPipe1X;
    assign pipe_x[1] = iPipe2X;
    assign pipe_x[2] = iPipe3X;
    assign pipe_y[0] = iPipe1Y;
    assign pipe_y[1] = iPipe2Y;
    assign pipe_y[2] = iPipe3Y;
    assign vel_ext   = 32'(vel_q);

    // arm_q stays low for the first clock after reset so a button held through release is not a press
    assign flap_pulse = iFlap & ~flap_q & arm_q;

    always_comb begin
        collide = (bird_y_q < 0) || (bird_y_q + BIRD_SIZE_S > SCREEN_H_S);
        for (int i = 0; i < 3; i++) begin
            if (pipe_y[i] != NO_PIPE && pipe_x[i] < BIRD_R_S && pipe_x[i] + PIPE_W_S > BIRD_X_S &&
                (bird_y_q < pipe_y[i] || bird_y_q + BIRD_SIZE_S > pipe_y[i] + GAP_S)) begin
                collide = 1'b1;
            end
        end
    end

    always_comb begin
        passed_nxt = passed_q;
        pass_cnt   = 2'd0;
        for (int i = 0; i < 3; i++) begin
            if (pipe_x[i] + PIPE_W_S < BIRD_X_S) begin
                if (pipe_y[i] != NO_PIPE && !passed_q[i]) begin
                    passed_nxt[i] = 1'b1;
                    pass_cnt      = pass_cnt + 2'd1;
                end
            end else begin
                passed_nxt[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bird_y_d = bird_y_q;
        vel_d    = vel_q;
        score_d  = score_q;
        tick_d   = tick_q;
        hold_d   = hold_q;
        passed_d = passed_q;
        case (state_q)
            S_IDLE: begin
                bird_y_d = START_Y_S;
                vel_d    = 8'sd0;
                if (flap_pulse) begin
                    state_d  = S_PLAYING;
                    score_d  = 16'd0;
                    passed_d = 3'b000;
                    tick_d   = 32'd0;
                    vel_d    = FLAP_V_S;
                end
            end
            S_PLAYING: begin
                // a collision freezes position, velocity and score for the game-over screen
                if (collide) begin
                    state_d = S_GAMEOVER;
                    hold_d  = 32'd0;
                end else begin
                    score_d  = sat_add(score_q, pass_cnt);
                    passed_d = passed_nxt;
                    if (tick_q == TICK_LAST) begin
                        tick_d   = 32'd0;
                        bird_y_d = bird_y_q + vel_ext;
                        vel_d    = apply_gravity(vel_q);
                    end else begin
                        tick_d = tick_q + 32'd1;
                    end
                    if (flap_pulse) vel_d = FLAP_V_S;
                end
            end
            S_GAMEOVER: begin
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 32'd1;
                end else if (flap_pulse) begin
                    state_d  = S_IDLE;
                    bird_y_d = START_Y_S;
                    vel_d    = 8'sd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q  <= S_IDLE;
            bird_y_q <= START_Y_S;
            vel_q    <= 8'sd0;
            score_q  <= 16'd0;
            tick_q   <= 32'd0;
            hold_q   <= 32'd0;
            passed_q <= 3'b000;
            flap_q   <= 1'b0;
            arm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bird_y_q <= bird_y_d;
            vel_q    <= vel_d;
            score_q  <= score_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            passed_q <= passed_d;
            flap_q   <= iFlap;
            arm_q    <= 1'b1;
        end
    end

    assign oState = state_q;
    assign oBirdY = bird_y_q;
    assign oScore = score_q;

endmodule

// File: doc/game_state_controller.md
GAME_STATE_CONTROLLER -- requirements
Module: game_state_controller

Interface
REQ-001 Parameter TICK_DIVIDER, default 50000: clocks per physics step.
REQ-002 Parameter SCREEN_HEIGHT, default 480: playfield height in pixels.
REQ-003 Parameter BIRD_X, default 120: fixed bird left edge in pixels.
REQ-004 Parameter BIRD_SIZE, default 24: bird square side in pixels.
REQ-005 Parameter PIPE_WIDTH, default 52; PIPE_GAP_HEIGHT, default 100: pipe geometry.
REQ-006 Parameter START_Y, default 240; FLAP_VELOCITY, default -8; GRAVITY, default 1; MAX_FALL, default 8; HOLD_CYCLES, default 1000000.
REQ-007 iClock  input  1  sole clock; all state updates on its rising edge.
REQ-008 iReset  input  1  asynchronous, active-low reset.
REQ-009 iFlap  input  1  player button, active-high, synchronous to iClock.
REQ-010 iPipe1X..iPipe3X  input  32 each  signed pipe left edge.
REQ-011 iPipe1Y..iPipe3Y  input  32 each  signed gap top; -1 means pipe invalid.
REQ-012 oState  output  2  0=IDLE, 1=PLAYING, 2=GAMEOVER; drives the pipe controller's state input.
REQ-013 oBirdY  output  32  signed bird top edge.
REQ-014 oScore  output  16  unsigned pipes passed.

Function
REQ-015 Flap pulse SHALL be iFlap high while the previous-cycle sample of iFlap was low; one pulse per press.
REQ-016 IDLE: oBirdY held at START_Y, velocity 0; a flap pulse SHALL move to PLAYING next cycle, clear oScore, clear all passed flags, clear the tick counter, and set velocity to FLAP_VELOCITY.
REQ-017 PLAYING: tick counter increments every clock; at TICK_DIVIDER-1 it wraps to 0 and performs one physics step: oBirdY <= oBirdY + velocity; velocity <= min(velocity + GRAVITY, MAX_FALL).
REQ-018 A flap pulse in PLAYING SHALL set velocity to FLAP_VELOCITY; if coincident with a physics step, the Y update uses the old velocity and the flap value overrides the gravity update.
REQ-019 All position arithmetic SHALL be 32-bit signed; velocity SHALL be at least 8-bit signed.
REQ-020 Collision conditions: oBirdY < 0; oBirdY + BIRD_SIZE > SCREEN_HEIGHT; or, for any pipe with Y != -1 that overlaps horizontally (pipeX < BIRD_X+BIRD_SIZE and pipeX+PIPE_WIDTH > BIRD_X), oBirdY < pipeY or oBirdY+BIRD_SIZE > pipeY+PIPE_GAP_HEIGHT.
REQ-021 Collision in PLAYING SHALL move to GAMEOVER on the next clock; collision takes priority over a same-cycle flap pulse.
REQ-022 Scoring: each pipe has a passed flag; when Y != -1, pipeX+PIPE_WIDTH < BIRD_X, and the flag is clear, oScore increments and the flag sets; the flag clears when pipeX+PIPE_WIDTH >= BIRD_X.
REQ-023 Simultaneous passes SHALL add their count in one cycle.
REQ-024 oScore SHALL saturate at 16'hFFFF.
REQ-025 Scoring SHALL be suppressed in the cycle a collision is detected.
REQ-026 GAMEOVER: oBirdY, velocity and oScore frozen; a hold counter counts HOLD_CYCLES clocks; flap pulses before expiry SHALL be ignored; a flap pulse after expiry SHALL move to IDLE, oBirdY <= START_Y, velocity <= 0, oScore retained.
REQ-027 oState value 3 SHALL never be output; if reached, next state is IDLE.
REQ-028 Outputs SHALL be registered; input-to-state-change latency is one clock.

Reset
REQ-029 While iReset is low, regardless of clock: oState=0, oBirdY=START_Y, velocity=0, oScore=0, tick and hold counters=0, passed flags=0, flap sample=0.
REQ-030 Reset asserted mid-PLAYING or mid-GAMEOVER SHALL abort immediately; after release the block waits in IDLE for a new flap press.
REQ-031 An iFlap held high through reset release SHALL NOT produce a pulse.

Verification (TICK_DIVIDER=4, HOLD_CYCLES=8, other defaults)
REQ-032 Reset release, one iFlap press -> oState=1 next clock, oScore=0; after 4 clocks oBirdY=232, after 8 clocks oBirdY=225.
REQ-033 No flaps from START_Y -> velocity saturates at 8, oBirdY passes 456 (480-24), oState=2 one clock later, oBirdY then frozen.
REQ-034 Pipe1X=100, Y=300, bird at 240 -> overlap and above gap -> GAMEOVER; same with Y=-1 -> no collision.
REQ-035 Pipe1X decreasing from 70 to 67 with Y=230, bird inside gap -> oScore 0->1 once; Pipe1X recycled to 600 and swept again -> oScore=2.
REQ-036 GAMEOVER: press at hold count 3 -> stays 2; press after 8 clocks -> oState=0, oBirdY=240, oScore retained.
REQ-037 Assert iReset low mid-PLAYING with iFlap high, release with iFlap still high -> oState=0 and stays 0 until iFlap drops and rises again.
